csr_trap_unit: RTL and testbench

Machine-mode CSR file and interrupt/trap sequencer for the 3-stage RISC-V pipeline.
- Executes CSR instructions retiring in the MW stage.
- Samples the timer and external interrupt lines and decides when a trap is taken.
- Drives the `interrupt` and `is_mret` signals that the hazard/forwarding logic consumes to flush the pipeline.
- Supplies the redirect PC (mtvec entry or mepc) to the fetch stage.

---
 rtl/csr_pkg.sv | 32 +++
 rtl/csr_regfile.sv | 115 +++++++++++
 rtl/csr_trap_unit.sv | 108 ++++++++++
 tb/tb_csr_trap_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, bit indices, cause codes and trap state encoding
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // MTIP/MEIP in mip share the MTIE/MEIE positions of mie
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MTIE_BIT = 7;
    localparam int MEIE_BIT = 11;

    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    localparam logic [1:0] INTR_NONE    = 2'b00;
    localparam logic [1:0] INTR_TAKE    = 2'b01;
    localparam logic [1:0] INTR_HANDLER = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } trap_state_e;

endpackage

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine CSR storage, read mux and RW/RS/RC write logic
// Honours CSR_VECTORED_MTVEC_EN (mtvec[0] writable as mode bit).
module csr_regfile
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     addr,
    input  logic            we,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand,
    input  logic            timer_irq,
    input  logic            ext_irq,
    input  logic            trap_take,
    input  logic            trap_ext,
    input  logic [XLEN-1:0] trap_epc,
    input  logic            mret,
    output logic [XLEN-1:0] rdata,
    output logic            mstatus_mie,
    output logic            mie_mtie,
    output logic            mie_meie,
    output logic [XLEN-1:0] mepc_q,
    output logic [XLEN-1:0] mtvec_q
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};
`else
    localparam logic [XLEN-1:0] MTVEC_MASK = ALIGN_MASK;
`endif

    logic            mie_b, mpie_b, mtie_b, meie_b;
    logic [XLEN-1:0] mtvec_r, mepc_r, mcause_r;
    logic [XLEN-1:0] wval;

    always_comb begin
        rdata = '0;
        case (addr)
            CSR_MSTATUS: begin
                rdata[MIE_BIT]  = mie_b;
                rdata[MPIE_BIT] = mpie_b;
            end
            CSR_MIE: begin
                rdata[MTIE_BIT] = mtie_b;
                rdata[MEIE_BIT] = meie_b;
            end
            CSR_MTVEC:  rdata = mtvec_r;
            CSR_MEPC:   rdata = mepc_r;
            CSR_MCAUSE: rdata = mcause_r;
            CSR_MIP: begin
                rdata[MTIE_BIT] = timer_irq;
                rdata[MEIE_BIT] = ext_irq;
            end
            default:    rdata = '0;
        endcase
    end

    always_comb begin
        case (op)
            2'b10:   wval = rdata | operand;
            2'b11:   wval = rdata & ~operand;
            default: wval = operand;
        endcase
    end

    // Trap and mret updates are placed after the CSR write so they override it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_b    <= 1'b0;
            mpie_b   <= 1'b0;
            mtie_b   <= 1'b0;
            meie_b   <= 1'b0;
            mtvec_r  <= MTVEC_RST & MTVEC_MASK;
            mepc_r   <= '0;
            mcause_r <= '0;
        end else begin
            if (we) begin
                case (addr)
                    CSR_MSTATUS: begin
                        mie_b  <= wval[MIE_BIT];
                        mpie_b <= wval[MPIE_BIT];
                    end
                    CSR_MIE: begin
                        mtie_b <= wval[MTIE_BIT];
                        meie_b <= wval[MEIE_BIT];
                    end
                    CSR_MTVEC:  mtvec_r  <= wval & MTVEC_MASK;
                    CSR_MEPC:   mepc_r   <= wval & ALIGN_MASK;
                    CSR_MCAUSE: mcause_r <= wval;
                    default: ;
                endcase
            end
            if (trap_take) begin
                mepc_r   <= trap_epc & ALIGN_MASK;
                mcause_r <= {1'b1, {(XLEN-5){1'b0}}, trap_ext ? CAUSE_MEI : CAUSE_MTI};
                mpie_b   <= mie_b;
                mie_b    <= 1'b0;
            end else if (mret) begin
                mie_b    <= mpie_b;
                mpie_b   <= 1'b1;
            end
        end
    end

    assign mstatus_mie = mie_b;
    assign mie_mtie    = mtie_b;
    assign mie_meie    = meie_b;
    assign mepc_q      = mepc_r;
    assign mtvec_q     = mtvec_r;

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - CSR decode, interrupt take logic and trap FSM for the MW stage
// Honours CSR_VECTORED_MTVEC_EN (vectored interrupt entry when mtvec mode=1).
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     inst_MW,
    input  logic            valid_MW,
    input  logic [XLEN-1:0] pc_MW,
    input  logic [XLEN-1:0] next_pc,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            timer_irq,
    input  logic            ext_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic [1:0]      interrupt,
    output logic            is_mret,
    output logic [XLEN-1:0] trap_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [2:0]      funct3;
    logic [4:0]      rs1_field;
    logic            is_csr, csr_we, mret_hit, take, take_ext;
    logic [XLEN-1:0] csr_operand, rf_rdata, mepc_q, mtvec_q, vector;
    logic            mstatus_mie, mie_mtie, mie_meie;
    logic            unused_pc;
    trap_state_e     state_q, state_d;

    assign unused_pc = ^pc_MW;

    assign funct3      = inst_MW[14:12];
    assign rs1_field   = inst_MW[19:15];
    assign is_csr      = (inst_MW[6:0] == OPC_SYSTEM) && (funct3[1:0] != 2'b00);
    assign csr_operand = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_field} : csr_wdata;
    // Set/clear forms with a zero source must not write (CSRs with side effects)
    assign csr_we      = valid_MW && is_csr && !(funct3[1] && rs1_field == 5'd0);
    assign mret_hit    = valid_MW && (inst_MW == INST_MRET);

    assign take_ext = mie_meie && ext_irq;
    assign take     = (state_q == IDLE) && mstatus_mie && (take_ext || (mie_mtie && timer_irq))
                      && valid_MW && !mret_hit;

`ifdef CSR_VECTORED_MTVEC_EN
    assign vector = mtvec_q[0]
                  ? (mtvec_q & ALIGN_MASK) + {{(XLEN-6){1'b0}}, take_ext ? CAUSE_MEI : CAUSE_MTI, 2'b00}
                  : (mtvec_q & ALIGN_MASK);
`else
    assign vector = mtvec_q & ALIGN_MASK;
`endif

    csr_regfile #(
        .XLEN      (XLEN),
        .MTVEC_RST (MTVEC_RST)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (inst_MW[31:20]),
        .we          (csr_we),
        .op          (funct3[1:0]),
        .operand     (csr_operand),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .trap_take   (take),
        .trap_ext    (take_ext),
        .trap_epc    (next_pc),
        .mret        (mret_hit),
        .rdata       (rf_rdata),
        .mstatus_mie (mstatus_mie),
        .mie_mtie    (mie_mtie),
        .mie_meie    (mie_meie),
        .mepc_q      (mepc_q),
        .mtvec_q     (mtvec_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        interrupt = INTR_NONE;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d   = HANDLER;
                    interrupt = INTR_TAKE;
                end
            end
            HANDLER: begin
                interrupt = INTR_HANDLER;
                if (mret_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational outputs are held at zero while reset is asserted
    assign is_mret   = rst_n && mret_hit;
    assign csr_rdata = (rst_n && is_csr) ? rf_rdata : '0;
    assign trap_pc   = take ? vector : (is_mret ? mepc_q : '0);

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb/tb_csr_trap_unit.sv - self-checking bench for csr_trap_unit with a behavioural CSR/trap model
module tb_csr_trap_unit;

    localparam logic [31:0] MRET = 32'h3020_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef CSR_VECTORED_MTVEC_EN
    localparam bit          VEC        = 1'b1;
    localparam logic [31:0] MTVEC_KEEP = 32'hFFFF_FFFD;
`else
    localparam bit          VEC        = 1'b0;
    localparam logic [31:0] MTVEC_KEEP = 32'hFFFF_FFFC;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_MW = '0, pc_MW = '0, next_pc = '0, csr_wdata = '0;
    logic        valid_MW = 1'b0, timer_irq = 1'b0, ext_irq = 1'b0;
    logic [31:0] csr_rdata, trap_pc;
    logic [1:0]  interrupt;
    logic        is_mret;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural model
    logic [31:0] m_mstatus, m_mie_reg, m_mtvec, m_mepc, m_mcause;
    bit          m_handler;
    // Predictions for the current cycle
    logic [1:0]  exp_int;
    logic        exp_mret;
    logic [31:0] exp_pc, exp_rdata;
    bit          p_csr, p_take, p_ext, p_old_mie;

    csr_trap_unit dut (
        .clk(clk), .rst_n(rst_n), .inst_MW(inst_MW), .valid_MW(valid_MW), .pc_MW(pc_MW),
        .next_pc(next_pc), .csr_wdata(csr_wdata), .timer_irq(timer_irq), .ext_irq(ext_irq),
        .csr_rdata(csr_rdata), .interrupt(interrupt), .is_mret(is_mret), .trap_pc(trap_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] csr_i(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] rs);
        return {a, rs, f3, 5'd1, 7'b1110011};
    endfunction

    function automatic logic [31:0] rd(input logic [11:0] a);
        return csr_i(3'd2, a, 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return (timer_irq ? 32'h80 : 32'h0) | (ext_irq ? 32'h800 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mie_reg = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_handler = 0;
    endtask

    task automatic predict();
        bit pend_e, pend_t;
        logic [31:0] vec;
        p_csr     = (inst_MW[6:0] == 7'h73) && (inst_MW[14:12] inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7});
        exp_mret  = valid_MW && (inst_MW == MRET);
        pend_e    = m_mie_reg[11] && ext_irq;
        pend_t    = m_mie_reg[7] && timer_irq;
        p_take    = !m_handler && m_mstatus[3] && (pend_e || pend_t) && valid_MW && !exp_mret;
        p_ext     = pend_e;
        p_old_mie = m_mstatus[3];
        vec = m_mtvec & 32'hFFFF_FFFC;
        if (VEC && m_mtvec[0]) vec = vec + 4 * (pend_e ? 11 : 7);
        exp_int   = m_handler ? 2'b10 : (p_take ? 2'b01 : 2'b00);
        exp_pc    = p_take ? vec : (exp_mret ? m_mepc : 32'h0);
        exp_rdata = p_csr ? m_read(inst_MW[31:20]) : 32'h0;
    endtask

    task automatic commit();
        logic [31:0] old, src, nv;
        if (valid_MW && p_csr) begin
            old = m_read(inst_MW[31:20]);
            src = inst_MW[14] ? {27'd0, inst_MW[19:15]} : csr_wdata;
            case (inst_MW[13:12])
                2'd1:    nv = src;
                2'd2:    nv = old | src;
                default: nv = old & ~src;
            endcase
            if (!(inst_MW[13] && inst_MW[19:15] == 5'd0)) begin
                case (inst_MW[31:20])
                    12'h300: m_mstatus = nv & 32'h88;
                    12'h304: m_mie_reg = nv & 32'h880;
                    12'h305: m_mtvec   = nv & MTVEC_KEEP;
                    12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
                    12'h342: m_mcause  = nv;
                    default: ;
                endcase
            end
        end
        if (p_take) begin
            m_mepc    = next_pc & 32'hFFFF_FFFC;
            m_mcause  = p_ext ? 32'h8000_000B : 32'h8000_0007;
            m_mstatus = p_old_mie ? 32'h80 : 32'h0;
            m_handler = 1;
        end else if (exp_mret) begin
            m_mstatus = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
            m_handler = 0;
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic v, input logic [31:0] pc,
                         input logic [31:0] npc, input logic [31:0] wd, input logic t, input logic e);
        inst_MW = inst; valid_MW = v; pc_MW = pc; next_pc = npc; csr_wdata = wd;
        timer_irq = t; ext_irq = e;
        @(negedge clk);
        predict();
    endtask

    task automatic advance();
        commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i == 1 ? rd(12'h344) : MRET, 1'b1, 32'h40, 32'h44, 32'hFFFF_FFFF, 1'b1, 1'b1);
            n_tests++; if (interrupt !== 2'b00) begin n_fail++; $display("FAIL rst_interrupt got %h want 0", interrupt); end
            n_tests++; if (is_mret !== 1'b0) begin n_fail++; $display("FAIL rst_is_mret got %b want 0", is_mret); end
            n_tests++; if (trap_pc !== 32'h0) begin n_fail++; $display("FAIL rst_trap_pc got %h want 0", trap_pc); end
            n_tests++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_csr_rdata got %h want 0", csr_rdata); end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        drive(rd(12'h305), 1'b1, 0, 4, 0, 1'b0, 1'b0);
        n_tests++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mtvec got %h want 0", csr_rdata); end
        advance();
        drive(rd(12'h300), 1'b1, 4, 8, 0, 1'b0, 1'b0);
        n_tests++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mstatus got %h want 0", csr_rdata); end
        advance();
    endtask

    task automatic test_ext_trap();
        drive(csr_i(3'd1, 12'h305, 5'd5), 1'b1, 0, 4, 32'h100, 1'b0, 1'b0); advance();
        drive(csr_i(3'd6, 12'h300, 5'd8), 1'b1, 4, 8, 0, 1'b0, 1'b0); advance();
        drive(csr_i(3'd1, 12'h304, 5'd5), 1'b1, 8, 12, 32'h800, 1'b0, 1'b0); advance();
        drive(NOP, 1'b1, 32'h40, 32'h44, 0, 1'b0, 1'b1);
        n_tests++; if (interrupt !== 2'b01) begin n_fail++; $display("FAIL ext_take_int got %h want 1", interrupt); end
        n_tests++; if (trap_pc !== 32'h100) begin n_fail++; $display("FAIL ext_take_pc got %h want 100", trap_pc); end
        advance();
        drive(rd(12'h341), 1'b1, 32'h100, 32'h104, 0, 1'b0, 1'b1);
        n_tests++; if (interrupt !== 2'b10) begin n_fail++; $display("FAIL ext_handler_int got %h want 2", interrupt); end
        n_tests++; if (csr_rdata !== 32'h44) begin n_fail++; $display("FAIL ext_mepc got %h want 44", csr_rdata); end
        advance();
        drive(rd(12'h342), 1'b1, 32'h104, 32'h108, 0, 1'b0, 1'b1);
        n_tests++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL ext_mcause got %h want 8000000b", csr_rdata); end
        advance();
        drive(rd(12'h300), 1'b1, 32'h108, 32'h10C, 0, 1'b0, 1'b1);
        n_tests++; if (csr_rdata !== 32'h80) begin n_fail++; $display("FAIL ext_mstatus got %h want 80", csr_rdata); end
        advance();
    endtask

    task automatic test_mret();
        drive(MRET, 1'b1, 32'h10C, 32'h110, 0, 1'b0, 1'b0);
        n_tests++; if (is_mret !== 1'b1) begin n_fail++; $display("FAIL mret_flag got %b want 1", is_mret); end
        n_tests++; if (trap_pc !== 32'h44) begin n_fail++; $display("FAIL mret_pc got %h want 44", trap_pc); end
        advance();
        drive(rd(12'h300), 1'b1, 32'h44, 32'h48, 0, 1'b0, 1'b0);
        n_tests++; if (interrupt !== 2'b00) begin n_fail++; $display("FAIL mret_idle got %h want 0", interrupt); end
        n_tests++; if (csr_rdata !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus got %h want 88", csr_rdata); end
        advance();
    endtask

    task automatic test_priority();
        drive(csr_i(3'd1, 12'h304, 5'd5), 1'b1, 32'h48, 32'h4C, 32'h880, 1'b0, 1'b0); advance();
        drive(NOP, 1'b1, 32'h60, 32'h64, 0, 1'b1, 1'b1);
        n_tests++; if (interrupt !== 2'b01) begin n_fail++; $display("FAIL prio_take got %h want 1", interrupt); end
        advance();
        drive(rd(12'h342), 1'b1, 32'h100, 32'h104, 0, 1'b1, 1'b1);
        n_tests++; if (csr_rdata !== 32'h8000_000B) begin n_fail++; $display("FAIL prio_both_cause got %h want 8000000b", csr_rdata); end
        advance();
        drive(MRET, 1'b1, 32'h104, 32'h108, 0, 1'b0, 1'b0); advance();
        drive(NOP, 1'b1, 32'h70, 32'h74, 0, 1'b1, 1'b0);
        n_tests++; if (trap_pc !== 32'h100) begin n_fail++; $display("FAIL prio_timer_pc got %h want 100", trap_pc); end
        advance();
        drive(rd(12'h342), 1'b1, 32'h100, 32'h104, 0, 1'b1, 1'b0);
        n_tests++; if (csr_rdata !== 32'h8000_0007) begin n_fail++; $display("FAIL prio_timer_cause got %h want 80000007", csr_rdata); end
        advance();
        drive(MRET, 1'b1, 32'h104, 32'h108, 0, 1'b0, 1'b0); advance();
    endtask

    task automatic test_mret_vs_irq();
        drive(csr_i(3'd1, 12'h300, 5'd5), 1'b1, 32'h74, 32'h78, 32'h80, 1'b0, 1'b0); advance();
        drive(MRET, 1'b1, 32'h80, 32'h84, 0, 1'b0, 1'b1);
        n_tests++; if (is_mret !== 1'b1) begin n_fail++; $display("FAIL mvi_mret got %b want 1", is_mret); end
        n_tests++; if (interrupt !== 2'b00) begin n_fail++; $display("FAIL mvi_int got %h want 0", interrupt); end
        n_tests++; if (trap_pc !== 32'h74) begin n_fail++; $display("FAIL mvi_pc got %h want 74", trap_pc); end
        advance();
        drive(NOP, 1'b0, 32'h90, 32'h94, 0, 1'b0, 1'b1);
        n_tests++; if (interrupt !== 2'b00) begin n_fail++; $display("FAIL mvi_invalid got %h want 0", interrupt); end
        advance();
        drive(NOP, 1'b1, 32'h90, 32'h94, 0, 1'b0, 1'b1);
        n_tests++; if (interrupt !== 2'b01) begin n_fail++; $display("FAIL mvi_take got %h want 1", interrupt); end
        advance();
        drive(rd(12'h341), 1'b1, 32'h100, 32'h104, 0, 1'b0, 1'b0);
        n_tests++; if (csr_rdata !== 32'h94) begin n_fail++; $display("FAIL mvi_mepc got %h want 94", csr_rdata); end
        advance();
        drive(MRET, 1'b1, 32'h104, 32'h108, 0, 1'b0, 1'b0); advance();
    endtask

    task automatic test_vector();
        drive(csr_i(3'd1, 12'h305, 5'd5), 1'b1, 32'h94, 32'h98, 32'h101, 1'b0, 1'b0); advance();
        drive(rd(12'h305), 1'b1, 32'h98, 32'h9C, 0, 1'b0, 1'b0);
        n_tests++; if (csr_rdata !== (VEC ? 32'h101 : 32'h100)) begin n_fail++; $display("FAIL vec_mtvec got %h want %h", csr_rdata, VEC ? 32'h101 : 32'h100); end
        advance();
        drive(NOP, 1'b1, 32'hA0, 32'hA4, 0, 1'b1, 1'b0);
        n_tests++; if (trap_pc !== (VEC ? 32'h11C : 32'h100)) begin n_fail++; $display("FAIL vec_timer_pc got %h want %h", trap_pc, VEC ? 32'h11C : 32'h100); end
        advance();
        drive(MRET, 1'b1, 32'h11C, 32'h120, 0, 1'b0, 1'b0); advance();
        drive(NOP, 1'b1, 32'hB0, 32'hB4, 0, 1'b0, 1'b1);
        n_tests++; if (trap_pc !== (VEC ? 32'h12C : 32'h100)) begin n_fail++; $display("FAIL vec_ext_pc got %h want %h", trap_pc, VEC ? 32'h12C : 32'h100); end
        advance();
        drive(MRET, 1'b1, 32'h12C, 32'h130, 0, 1'b0, 1'b0); advance();
    endtask

    task automatic test_reset_mid_trap();
        drive(NOP, 1'b1, 32'hC0, 32'hC4, 0, 1'b0, 1'b1); advance();
        drive(NOP, 1'b1, 32'hC4, 32'hC8, 0, 1'b0, 1'b1);
        n_tests++; if (interrupt !== 2'b10) begin n_fail++; $display("FAIL mid_handler got %h want 2", interrupt); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (interrupt !== 2'b00) begin n_fail++; $display("FAIL mid_async_int got %h want 0", interrupt); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(rd(12'h300), 1'b1, 32'hC8, 32'hCC, 0, 1'b0, 1'b1);
        n_tests++; if (interrupt !== 2'b00) begin n_fail++; $display("FAIL mid_after_int got %h want 0", interrupt); end
        n_tests++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_mstatus got %h want 0", csr_rdata); end
        advance();
        drive(rd(12'h304), 1'b1, 32'hCC, 32'hD0, 0, 1'b0, 1'b1);
        n_tests++; if (csr_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_mie got %h want 0", csr_rdata); end
        advance();
    endtask

    task automatic test_random();
        logic [11:0] addrs [7];
        logic [2:0]  f3s [6];
        logic [31:0] inst;
        logic [4:0]  rs;
        int          r;
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h000};
        f3s   = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                addrs[6] = 12'($urandom);
                rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                inst = csr_i(f3s[$urandom_range(0, 5)], addrs[$urandom_range(0, 6)], rs);
            end else if (r < 8) begin
                inst = MRET;
            end else begin
                inst = NOP;
            end
            drive(inst, $urandom_range(0, 4) != 0, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_tests++; if (interrupt !== exp_int) begin n_fail++; $display("FAIL rnd_interrupt[%0d] got %h want %h", i, interrupt, exp_int); end
            n_tests++; if (is_mret !== exp_mret) begin n_fail++; $display("FAIL rnd_is_mret[%0d] got %b want %b", i, is_mret, exp_mret); end
            n_tests++; if (trap_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_trap_pc[%0d] got %h want %h", i, trap_pc, exp_pc); end
            n_tests++; if (csr_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_csr_rdata[%0d] got %h want %h", i, csr_rdata, exp_rdata); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_ext_trap();
        test_mret();
        test_priority();
        test_mret_vs_irq();
        test_vector();
        test_reset_mid_trap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
